skin_bbox_tracker: RTL and testbench
====================================

// Module: skin_bbox_tracker
// PURPOSE
//  Consumes the per-pixel binary skin mask from the RGB->YCbCr skin detector. Skin pixels are full-white 10-bit RGB; others are black.
//  Rejects speckle with a horizontal run-length filter.
//  Accumulates per-frame bounding box and skin-pixel count, then publishes them once per frame to the display overlay and gesture logic.
// PARAMETERS
//  H_ACTIVE    640   active pixels per line
//  V_ACTIVE    480   active lines per frame
//  X_W         10    x coordinate width
//  Y_W         10    y coordinate width
//  CNT_W       19    skin pixel counter width (>= log2(H_ACTIVE*V_ACTIVE))
//  RUN_MIN     4     consecutive skin pixels on a line before they count (1..15)
//  MIN_PIXELS  256   frame count below which the box is declared invalid
// PORTS
//  iCLK        in   1      pixel clock
//  iRST_N      in   1      asynchronous, active-low reset
//  iSOF        in   1      start-of-frame pulse, aligned with the first mask pixel
//  iDVAL       in   1      mask pixel valid (aligned to the detector output)
//  iRed        in   10     detector output R
//  iGreen      in   10     detector output G
//  iBlue       in   10     detector output B
//  oFrameDone  out  1      one-cycle pulse: result registers updated
//  oBoxValid   out  1      last completed frame had count >= MIN_PIXELS
//  oXMin       out  X_W    bounding box left
//  oXMax       out  X_W    bounding box right
//  oYMin       out  Y_W    bounding box top
//  oYMax       out  Y_W    bounding box bottom
//  oCount      out  CNT_W  qualified skin pixels in the last frame
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; accumulators cleared.
//  - Mask bit = iRed[9] & iGreen[9] & iBlue[9].
//  - FSM: IDLE -(iSOF)-> ACTIVE -(last pixel accepted)-> PUBLISH -(1 cyc)-> IDLE.
//  - ACTIVE: X increments on each iDVAL; at X==H_ACTIVE-1 X wraps to 0 and Y increments.
//    The pixel with X==H_ACTIVE-1 and Y==V_ACTIVE-1 is the last pixel.
//  - iSOF in any state: restarts the frame.
//    Accumulators and run counter are cleared; X=Y=0; no oFrameDone for the aborted frame.
//    If iDVAL is high in the same cycle, that pixel is (0,0) of the new frame.
//  - Run filter: run counter saturates at RUN_MIN. It clears on a mask-0 pixel and on line wrap; runs never span lines.
//  - The pixel that makes run==RUN_MIN qualifies the run:
//    start column xs = X-(RUN_MIN-1); count += RUN_MIN.
//    Update xmin with xs, xmax with X, ymin/ymax with Y.
//  - Each further mask-1 pixel in a qualified run: count += 1; xmax = max(xmax, X).
//  - Accumulator init per frame: xmin = H_ACTIVE-1, ymin = V_ACTIVE-1, xmax = ymax = 0, count = 0.
//  - PUBLISH: all result outputs load together and oFrameDone=1 for exactly one cycle.
//    This happens 1 cycle after the last pixel's iDVAL.
//    If count >= MIN_PIXELS: box, count and oBoxValid=1 are loaded.
//    Else: box = 0, oCount = count, oBoxValid=0.
//  - Outputs hold between PUBLISH cycles.
//  - iDVAL in IDLE (no iSOF seen) is ignored.
//  - Counter overflow is impossible by the CNT_W rule; no saturation logic.
//  - Mid-frame async reset: immediate return to reset state; the next frame needs a fresh iSOF.
// STRUCTURE
//  - Shared header skin_defs.vh: FSM state encodings (IDLE/ACTIVE/PUBLISH) and default H_ACTIVE/V_ACTIVE/X_W/Y_W.
//  - Sub-module skin_run_filter: mask, iDVAL, line-wrap and clear in; qualify pulse, in-run flag and run-start column out.
//  - Top level holds X/Y counters, min/max/count accumulators, FSM and output registers.
// TESTING
//  1. Reset with no stimulus -> all outputs 0, oFrameDone never asserts.
//  2. Full 640x480 frame, skin rect x=100..199, y=50..149 (RUN_MIN=4):
//     one oFrameDone 1 cyc after the last pixel.
//     Outputs: XMin=100, XMax=199, YMin=50, YMax=149, Count=10000, BoxValid=1.
//  3. Frame with isolated 3-pixel skin runs only -> Count=0, BoxValid=0, box outputs 0.
//  4. Run of 8 skin pixels crossing a line wrap (x=636..639, next line x=0..3), alone in frame:
//     Count=8, XMin=0, XMax=639. MIN_PIXELS=1 for this case.
//  5. iSOF reasserted mid-frame at line 200, then a clean frame with a 10x10 rect at (0,0):
//     single oFrameDone; XMin=0, XMax=9, YMin=0, YMax=9, Count=100.
//  6. iRST_N pulsed low mid-frame -> outputs 0 asynchronously.
//     The following iDVAL without iSOF is ignored; no oFrameDone.

Source files
------------

// File: rtl/skin_bbox_tracker_pkg.sv
// skin_bbox_tracker_pkg: shared FSM encoding and default geometry for the skin bounding-box tracker
package skin_bbox_tracker_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, PUBLISH = 2'd2} state_t;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_X_W      = 10;
    localparam int DEF_Y_W      = 10;
    localparam int RUN_W        = 4;
endpackage

// File: rtl/skin_bbox_tracker_run_filter.sv
// skin_bbox_tracker_run_filter: horizontal run-length speckle filter producing qualify/in-run strobes
module skin_bbox_tracker_run_filter
    import skin_bbox_tracker_pkg::*;
#(
    parameter int X_W     = DEF_X_W,
    parameter int RUN_MIN = 4
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    input  logic           iMask,
    input  logic           iValid,
    input  logic           iWrap,
    input  logic           iClear,
    input  logic [X_W-1:0] iX,
    output logic           oQualify,
    output logic           oInRun,
    output logic [X_W-1:0] oRunStart
);
    logic [RUN_W-1:0] runCnt, prevRun, nextRun;
    // a frame restart wipes the run before the coincident pixel is considered
    assign prevRun   = iClear ? '0 : runCnt;
    assign oQualify  = iValid & iMask & (prevRun == RUN_W'(RUN_MIN - 1));
    assign oInRun    = iValid & iMask & (prevRun == RUN_W'(RUN_MIN));
    assign oRunStart = iX - X_W'(RUN_MIN - 1);
    assign nextRun   = (!iMask || iWrap) ? '0 :
                       (prevRun == RUN_W'(RUN_MIN)) ? prevRun : prevRun + RUN_W'(1);
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) runCnt <= '0;
        else         runCnt <= iValid ? nextRun : prevRun;
    end
endmodule

// File: rtl/skin_bbox_tracker.sv
// skin_bbox_tracker: per-frame bounding box and qualified skin-pixel count from the detector mask
module skin_bbox_tracker
    import skin_bbox_tracker_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int CNT_W      = 19,
    parameter int RUN_MIN    = 4,
    parameter int MIN_PIXELS = 256
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSOF,
    input  logic             iDVAL,
    input  logic [9:0]       iRed,
    input  logic [9:0]       iGreen,
    input  logic [9:0]       iBlue,
    output logic             oFrameDone,
    output logic             oBoxValid,
    output logic [X_W-1:0]   oXMin,
    output logic [X_W-1:0]   oXMax,
    output logic [Y_W-1:0]   oYMin,
    output logic [Y_W-1:0]   oYMax,
    output logic [CNT_W-1:0] oCount
);
    state_t             state;
    logic [X_W-1:0]     xCnt, xMin, xMax, curX, runStart, nXMin, nXMax;
    logic [Y_W-1:0]     yCnt, yMin, yMax, curY, nYMin, nYMax;
    logic [CNT_W-1:0]   count, nCount;
    logic               mask, accept, lineEnd, lastPix, qualify, inRun, boxOk, unusedLow;
    assign mask      = iRed[9] & iGreen[9] & iBlue[9];
    assign unusedLow = ^{iRed[8:0], iGreen[8:0], iBlue[8:0]};
    // iSOF makes the coincident pixel (0,0) of a fresh frame regardless of state
    assign accept    = iDVAL & (iSOF | (state == ACTIVE));
    assign curX      = iSOF ? '0 : xCnt;
    assign curY      = iSOF ? '0 : yCnt;
    assign lineEnd   = curX == X_W'(H_ACTIVE - 1);
    assign lastPix   = accept & lineEnd & (curY == Y_W'(V_ACTIVE - 1));
    assign boxOk     = nCount >= CNT_W'(MIN_PIXELS);
    skin_bbox_tracker_run_filter #(.X_W(X_W), .RUN_MIN(RUN_MIN)) uRunFilter (
        .iCLK(iCLK), .iRST_N(iRST_N), .iMask(mask), .iValid(accept), .iWrap(lineEnd),
        .iClear(iSOF), .iX(curX), .oQualify(qualify), .oInRun(inRun), .oRunStart(runStart)
    );
    always_comb begin
        nXMin  = iSOF ? X_W'(H_ACTIVE - 1) : xMin;
        nXMax  = iSOF ? '0 : xMax;
        nYMin  = iSOF ? Y_W'(V_ACTIVE - 1) : yMin;
        nYMax  = iSOF ? '0 : yMax;
        nCount = iSOF ? '0 : count;
        if (qualify) begin
            nXMin  = (runStart < nXMin) ? runStart : nXMin;
            nYMin  = (curY < nYMin) ? curY : nYMin;
            nYMax  = (curY > nYMax) ? curY : nYMax;
            nCount = nCount + CNT_W'(RUN_MIN);
        end
        if (inRun) nCount = nCount + CNT_W'(1);
        if (qualify || inRun) nXMax = (curX > nXMax) ? curX : nXMax;
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            {xCnt, yCnt, xMin, xMax, yMin, yMax, count} <= '0;
            oFrameDone <= 1'b0;
            oBoxValid  <= 1'b0;
            {oXMin, oXMax, oYMin, oYMax, oCount} <= '0;
        end else begin
            state      <= iSOF ? ACTIVE : lastPix ? PUBLISH : (state == PUBLISH) ? IDLE : state;
            xCnt       <= accept ? (lineEnd ? '0 : curX + X_W'(1)) : curX;
            yCnt       <= (accept && lineEnd) ? curY + Y_W'(1) : curY;
            xMin       <= nXMin;
            xMax       <= nXMax;
            yMin       <= nYMin;
            yMax       <= nYMax;
            count      <= nCount;
            oFrameDone <= lastPix;
            if (lastPix) begin
                oBoxValid <= boxOk;
                oXMin     <= boxOk ? nXMin : '0;
                oXMax     <= boxOk ? nXMax : '0;
                oYMin     <= boxOk ? nYMin : '0;
                oYMax     <= boxOk ? nYMax : '0;
                oCount    <= nCount;
            end
        end
    end
endmodule

// File: tb/tb_skin_bbox_tracker.sv
// tb_skin_bbox_tracker: directed frame scenarios on a reduced 64x48 raster with hand-computed boxes
module tb_skin_bbox_tracker;
    localparam int H = 64, V = 48, XW = 10, YW = 10, CW = 19, RM = 4, MP = 8;
    logic          iCLK = 1'b0, iRST_N = 1'b0, iSOF = 1'b0, iDVAL = 1'b0;
    logic [9:0]    iRed = '0, iGreen = '0, iBlue = '0;
    logic          oFrameDone, oBoxValid;
    logic [XW-1:0] oXMin, oXMax;
    logic [YW-1:0] oYMin, oYMax;
    logic [CW-1:0] oCount;
    logic [59:0]   res;
    int            passed = 0, total = 0, doneSeen = 0;

    skin_bbox_tracker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW), .CNT_W(CW), .RUN_MIN(RM), .MIN_PIXELS(MP)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSOF(iSOF), .iDVAL(iDVAL), .iRed(iRed), .iGreen(iGreen),
        .iBlue(iBlue), .oFrameDone(oFrameDone), .oBoxValid(oBoxValid), .oXMin(oXMin), .oXMax(oXMax),
        .oYMin(oYMin), .oYMax(oYMax), .oCount(oCount)
    );

    always #5 iCLK = ~iCLK;
    assign res = {oBoxValid, oXMin, oXMax, oYMin, oYMax, oCount};

    function automatic bit skin(input int kind, input int x, input int y);
        case (kind)
            0: return x >= 10 && x <= 19 && y >= 5 && y <= 14;
            1: return (y % 4 == 0) && (x % 8 < 3);
            2: return (y == 20 && x >= 60) || (y == 21 && x <= 3);
            3: return x <= 9 && y <= 9;
            4: return y == 30 && x >= 5 && x <= 11;
            5: return (y == 3 && x >= 40 && x <= 44) || (y == 40 && x >= 2 && x <= 5) ||
                      (y == 45 && x >= 50 && x <= 52);
            default: return 1'b0;
        endcase
    endfunction

    // non-skin pixels alternate between black and near-white with one channel below threshold
    task automatic pixel(input bit sof, input bit dval, input bit m, input int x, input int y);
        iSOF  = sof;
        iDVAL = dval;
        if (m) {iRed, iGreen, iBlue} = {3{10'h3FF}};
        else if ((x + y) % 2 == 1) {iRed, iGreen, iBlue} = {10'h3FF, 10'h3FF, 10'h1FF};
        else {iRed, iGreen, iBlue} = '0;
        @(posedge iCLK);
        #1;
        if (oFrameDone) doneSeen++;
    endtask

    task automatic drive_frame(input int kind, input int stopLine);
        for (int y = 0; y < V; y++) begin
            if (y == stopLine) return;
            for (int x = 0; x < H; x++) pixel(x == 0 && y == 0, 1'b1, skin(kind, x, y), x, y);
            if (y != V - 1) pixel(1'b0, 1'b0, 1'b0, 0, 0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iCLK);
        #1;
        total++;
        if ({oFrameDone, res} !== 61'd0) $display("FAIL reset_state: got %h expected 0", {oFrameDone, res});
        else passed++;
        iRST_N = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) pixel(1'b0, 1'b1, 1'b1, i, 0);
        total++;
        if (doneSeen !== 0 || res !== 60'd0) $display("FAIL idle_ignored: done %0d res %h expected 0/0", doneSeen, res);
        else passed++;
    endtask

    task automatic test_frame(input string name, input int kind, input logic [59:0] exp);
        doneSeen = 0;
        drive_frame(kind, -1);
        total++;
        if (doneSeen !== 1 || oFrameDone !== 1'b1) $display("FAIL %s_done: pulses %0d now %b expected 1/1", name, doneSeen, oFrameDone);
        else passed++;
        total++;
        if (res !== exp) $display("FAIL %s_result: got %h expected %h", name, res, exp);
        else passed++;
        pixel(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_hold();
        repeat (5) pixel(1'b0, 1'b1, 1'b1, 0, 0);
        total++;
        if (oFrameDone !== 1'b0 || res !== {1'b1, 10'd10, 10'd19, 10'd5, 10'd14, 19'd100})
            $display("FAIL hold: done %b res %h expected 0 and held box", oFrameDone, res);
        else passed++;
    endtask

    task automatic test_restart();
        doneSeen = 0;
        drive_frame(0, 20);
        drive_frame(3, -1);
        total++;
        if (doneSeen !== 1 || oFrameDone !== 1'b1) $display("FAIL restart_done: pulses %0d now %b expected 1/1", doneSeen, oFrameDone);
        else passed++;
        total++;
        if (res !== {1'b1, 10'd0, 10'd9, 10'd0, 10'd9, 19'd100}) $display("FAIL restart_result: got %h expected %h", res, {1'b1, 10'd0, 10'd9, 10'd0, 10'd9, 19'd100});
        else passed++;
        pixel(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        doneSeen = 0;
        drive_frame(5, -1);
        total++;
        if (oFrameDone !== 1'b1 || res !== {1'b1, 10'd2, 10'd44, 10'd3, 10'd40, 19'd9}) $display("FAIL b2b_first: done %b res %h expected 1 %h", oFrameDone, res, {1'b1, 10'd2, 10'd44, 10'd3, 10'd40, 19'd9});
        else passed++;
        drive_frame(0, -1);
        total++;
        if (doneSeen !== 2 || oFrameDone !== 1'b1) $display("FAIL b2b_done: pulses %0d now %b expected 2/1", doneSeen, oFrameDone);
        else passed++;
        total++;
        if (res !== {1'b1, 10'd10, 10'd19, 10'd5, 10'd14, 19'd100}) $display("FAIL b2b_second: got %h expected %h", res, {1'b1, 10'd10, 10'd19, 10'd5, 10'd14, 19'd100});
        else passed++;
        pixel(1'b0, 1'b0, 1'b0, 0, 0);
        total++;
        if (oFrameDone !== 1'b0) $display("FAIL b2b_pulse_width: got %b expected 0", oFrameDone);
        else passed++;
    endtask

    task automatic test_async_reset();
        drive_frame(0, 10);
        #2 iRST_N = 1'b0;
        #1;
        total++;
        if ({oFrameDone, res} !== 61'd0) $display("FAIL async_reset: got %h expected 0", {oFrameDone, res});
        else passed++;
        @(posedge iCLK);
        #2 iRST_N = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < H * V + H; i++) pixel(1'b0, 1'b1, 1'b1, i % H, 0);
        total++;
        if (doneSeen !== 0) $display("FAIL post_reset_done: pulses %0d expected 0", doneSeen);
        else passed++;
        total++;
        if (res !== 60'd0) $display("FAIL post_reset_outputs: got %h expected 0", res);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_frame("rect", 0, {1'b1, 10'd10, 10'd19, 10'd5, 10'd14, 19'd100});
        test_hold();
        test_frame("short_runs", 1, 60'd0);
        test_frame("wrap", 2, {1'b1, 10'd0, 10'd63, 10'd20, 10'd21, 19'd8});
        test_frame("below_min", 4, {1'b0, 40'd0, 19'd7});
        test_frame("multi", 5, {1'b1, 10'd2, 10'd44, 10'd3, 10'd40, 19'd9});
        test_restart();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
